capture_sequencer: RTL and testbench

- Control FSM that sequences ADC capture into the ping-pong sample buffer.
- Detects the comparator trigger and counts samples into the active write bank.
- Swaps banks only when the FSMC host is not holding the read bank, and counts samples dropped while waiting (overrun).
- Sits between the synchronised ADC/comparator signals, the buffer RAM write port and the FSMC status register.

---
 rtl/capture_sequencer_if.sv | 57 +++++
 rtl/capture_sequencer.sv | 179 +++++++++++++++++
 tb/tb_capture_sequencer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/capture_sequencer_if.sv
// ---------------------------------------------------------------------------
// capture_sequencer_if
//   Bundle of signals between the capture sequencer and its surroundings:
//   the synchronised ADC/comparator inputs, the host control and status
//   lines, the ping-pong buffer write port, and the debug state code.
//
//   master : the capture sequencer (drives the buffer port and status).
//   slave  : the environment (ADC front end, FSMC host, buffer RAM).
//
//   Signals
//     sample_valid, sync_adc_data   ADC sample strobe and data
//     stable, sync_signal_in        front-end settled, comparator wave
//     arm, continuous, abort        acquisition control
//     host_lock                     host read in progress
//     buf_we, buf_bank, buf_waddr,
//     buf_wdata                     buffer RAM write port
//     rd_bank, frame_ready          bank handed to the host, frame flag
//     overrun_cnt, frame_cnt        dropped-sample and frame counters
//     state                         FSM state code
// ---------------------------------------------------------------------------
interface capture_sequencer_if #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 10
);
  logic                  sample_valid;
  logic [DATA_WIDTH-1:0] sync_adc_data;
  logic                  stable;
  logic                  sync_signal_in;
  logic                  arm;
  logic                  continuous;
  logic                  abort;
  logic                  host_lock;

  logic                  buf_we;
  logic                  buf_bank;
  logic [ADDR_WIDTH-1:0] buf_waddr;
  logic [DATA_WIDTH-1:0] buf_wdata;
  logic                  rd_bank;
  logic                  frame_ready;
  logic [15:0]           overrun_cnt;
  logic [15:0]           frame_cnt;
  logic [2:0]            state;

  modport master (
    input  sample_valid, sync_adc_data, stable, sync_signal_in,
           arm, continuous, abort, host_lock,
    output buf_we, buf_bank, buf_waddr, buf_wdata,
           rd_bank, frame_ready, overrun_cnt, frame_cnt, state
  );

  modport slave (
    output sample_valid, sync_adc_data, stable, sync_signal_in,
           arm, continuous, abort, host_lock,
    input  buf_we, buf_bank, buf_waddr, buf_wdata,
           rd_bank, frame_ready, overrun_cnt, frame_cnt, state
  );
endinterface

// File: rtl/capture_sequencer.sv
// ---------------------------------------------------------------------------
// capture_sequencer
//   Control FSM that sequences ADC capture into a ping-pong sample buffer.
//   Waits for a rising edge of the comparator wave, writes one frame of
//   2**ADDR_WIDTH samples into the active write bank, then hands that bank
//   to the host. The hand-over waits while the host holds the read bank;
//   samples arriving in that window are dropped and counted as overrun.
//
//   Ports
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    capture_sequencer_if.master (inputs, buffer port, status)
//
//   State codes: 0 IDLE, 1 WAIT_TRIG, 2 CAPTURE, 3 SWAP_WAIT.
//
//   Optional feature (macro CAPTURE_SEQUENCER_AUTO_TRIG_EN):
//     when defined, WAIT_TRIG counts samples taken while stable and forces
//     a trigger after AUTO_TRIG_SAMPLES of them; the AUTO_TRIG_SAMPLES
//     parameter exists only in that build. When undefined, WAIT_TRIG waits
//     for a comparator edge indefinitely.
// ---------------------------------------------------------------------------
module capture_sequencer #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 10
`ifdef CAPTURE_SEQUENCER_AUTO_TRIG_EN
  ,
  parameter int AUTO_TRIG_SAMPLES = 4096
`endif
) (
  input logic                 clk,
  input logic                 rst_n,
  capture_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TRIG = 3'd1,
    ST_CAPTURE   = 3'd2,
    ST_SWAP_WAIT = 3'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LastAddr = '1;

  state_t                state_q;
  logic                  sig_d;
  logic                  trig_rise;
  logic                  host_lock_d;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic                  buf_bank_q;
  logic                  rd_bank_q;
  logic                  frame_ready_q;
  logic [15:0]           overrun_q;
  logic [15:0]           frame_cnt_q;
  logic                  vld_p1;
  logic [ADDR_WIDTH-1:0] waddr_p1;
  logic [DATA_WIDTH-1:0] wdata_p1;
  logic                  auto_fire;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

`ifdef CAPTURE_SEQUENCER_AUTO_TRIG_EN
  localparam int AtW = $clog2(AUTO_TRIG_SAMPLES + 1);
  localparam logic [AtW-1:0] AtLast = AtW'(AUTO_TRIG_SAMPLES - 1);

  logic [AtW-1:0] at_cnt;

  // Fires on the sample that brings the count up to AUTO_TRIG_SAMPLES.
  assign auto_fire = (state_q == ST_WAIT_TRIG) & bus.stable &
                     bus.sample_valid & (at_cnt == AtLast);

  // Outside WAIT_TRIG the counter is held at zero, so every visit to
  // WAIT_TRIG starts a fresh count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      at_cnt <= '0;
    end else if (state_q != ST_WAIT_TRIG) begin
      at_cnt <= '0;
    end else if (bus.stable && bus.sample_valid) begin
      at_cnt <= at_cnt + AtW'(1);
    end
  end
`else
  assign auto_fire = 1'b0;
`endif

  // Stage p0 -> p1: sample strobe and data registered onto the write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      sig_d         <= 1'b0;
      trig_rise     <= 1'b0;
      host_lock_d   <= 1'b0;
      waddr_q       <= '0;
      buf_bank_q    <= 1'b0;
      rd_bank_q     <= 1'b1;
      frame_ready_q <= 1'b0;
      overrun_q     <= '0;
      frame_cnt_q   <= '0;
      vld_p1        <= 1'b0;
      waddr_p1      <= '0;
      wdata_p1      <= '0;
    end else begin
      sig_d       <= bus.sync_signal_in;
      trig_rise   <= bus.sync_signal_in & ~sig_d;
      host_lock_d <= bus.host_lock;
      vld_p1      <= 1'b0;

      // Host starting a read consumes the flag; a swap in this same
      // cycle (below) assigns it later and therefore wins.
      if (bus.host_lock && !host_lock_d) begin
        frame_ready_q <= 1'b0;
      end

      if (bus.abort) begin
        state_q <= ST_IDLE;
        waddr_q <= '0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (bus.arm || bus.continuous) begin
              state_q <= ST_WAIT_TRIG;
            end
          end

          ST_WAIT_TRIG: begin
            // A sample arriving in the trigger cycle is not written.
            if ((bus.stable && trig_rise) || auto_fire) begin
              state_q <= ST_CAPTURE;
              waddr_q <= '0;
            end
          end

          ST_CAPTURE: begin
            if (!bus.stable) begin
              // Front end lost lock: drop the partial frame, same bank.
              state_q <= ST_WAIT_TRIG;
              waddr_q <= '0;
            end else if (bus.sample_valid) begin
              vld_p1   <= 1'b1;
              waddr_p1 <= waddr_q;
              wdata_p1 <= bus.sync_adc_data;
              waddr_q  <= waddr_q + 1'b1;
              if (waddr_q == LastAddr) begin
                state_q <= ST_SWAP_WAIT;
              end
            end
          end

          ST_SWAP_WAIT: begin
            if (!bus.host_lock) begin
              buf_bank_q    <= ~buf_bank_q;
              rd_bank_q     <= buf_bank_q;
              frame_ready_q <= 1'b1;
              frame_cnt_q   <= frame_cnt_q + 16'd1;
              state_q       <= bus.continuous ? ST_WAIT_TRIG : ST_IDLE;
            end else if (bus.sample_valid) begin
              overrun_q <= sat_inc16(overrun_q);
            end
          end

          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.buf_we      = vld_p1;
  assign bus.buf_bank    = buf_bank_q;
  assign bus.buf_waddr   = waddr_p1;
  assign bus.buf_wdata   = wdata_p1;
  assign bus.rd_bank     = rd_bank_q;
  assign bus.frame_ready = frame_ready_q;
  assign bus.overrun_cnt = overrun_q;
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// ---------------------------------------------------------------------------
// tb_capture_sequencer
//   Directed bench for capture_sequencer. Expected buffer writes are kept in
//   a queue built from the stimulus (bank, frame index, sample value); a
//   negedge process matches every buf_we against it and checks that the
//   read and write banks always differ. Directed literal checks pin state,
//   banks, flags and counters at the key points of each scenario.
// ---------------------------------------------------------------------------
module tb_capture_sequencer;
  localparam int DW    = 12;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  typedef struct packed {
    logic          bank;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  capture_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) sif ();

  capture_sequencer #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
`ifdef CAPTURE_SEQUENCER_AUTO_TRIG_EN
    ,
    .AUTO_TRIG_SAMPLES(16)
`endif
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (sif.master)
  );

  int  total = 0;
  int  bad   = 0;
  wr_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] fdata(input int i, input int seed);
    return DW'(i * 37 + seed * 101 + 5);
  endfunction

  // Write-port scoreboard, sampled mid-cycle.
  logic prev_sv = 1'b0;
  always @(negedge clk) begin
    wr_t e;
    if (!rst_n) begin
      prev_sv = 1'b0;
    end else begin
      check("bank_split", 32'(sif.rd_bank != sif.buf_bank), 1);
      if (sif.buf_we) begin
        check("we_follows_strobe", 32'(prev_sv), 1);
        check("write_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("wr_bank", 32'(sif.buf_bank), 32'(e.bank));
          check("wr_addr", 32'(sif.buf_waddr), 32'(e.addr));
          check("wr_data", 32'(sif.buf_wdata), 32'(e.data));
        end
      end
      prev_sv = sif.sample_valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One strobe, then one idle clock (strobes at least 2 clk apart).
  task automatic sample(input logic [DW-1:0] d, input bit wr, input logic bank,
                        input logic [AW-1:0] addr);
    wr_t w;
    sif.sample_valid  = 1'b1;
    sif.sync_adc_data = d;
    if (wr) begin
      w.bank = bank;
      w.addr = addr;
      w.data = d;
      exp_q.push_back(w);
    end
    tick(1);
    sif.sample_valid = 1'b0;
    tick(1);
  endtask

  // Edge is registered once, then acted on: CAPTURE two clocks later.
  task automatic trigger();
    sif.sync_signal_in = 1'b1;
    tick(2);
    sif.sync_signal_in = 1'b0;
  endtask

  task automatic feed_frame(input logic bank, input int n, input int seed);
    for (int i = 0; i < n; i++) sample(fdata(i, seed), 1'b1, bank, AW'(i));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 32'(sif.state), 0);
    check({tag, "_buf_we"}, 32'(sif.buf_we), 0);
    check({tag, "_buf_bank"}, 32'(sif.buf_bank), 0);
    check({tag, "_rd_bank"}, 32'(sif.rd_bank), 1);
    check({tag, "_waddr"}, 32'(sif.buf_waddr), 0);
    check({tag, "_wdata"}, 32'(sif.buf_wdata), 0);
    check({tag, "_frame_ready"}, 32'(sif.frame_ready), 0);
    check({tag, "_overrun"}, 32'(sif.overrun_cnt), 0);
    check({tag, "_frame_cnt"}, 32'(sif.frame_cnt), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sif.sample_valid   = 1'b0;
    sif.sync_adc_data  = '0;
    sif.stable         = 1'b0;
    sif.sync_signal_in = 1'b0;
    sif.arm            = 1'b0;
    sif.continuous     = 1'b0;
    sif.abort          = 1'b0;
    sif.host_lock      = 1'b0;
    tick(2);
    check_reset_values("rst");
    rst_n = 1'b1;
    tick(1);

    // Single-shot frame into bank 0, host idle.
    sif.stable = 1'b1;
    sif.arm    = 1'b1;
    tick(1);
    sif.arm = 1'b0;
    check("arm_to_wait", 32'(sif.state), 1);
    trigger();
    check("trig_to_capture", 32'(sif.state), 2);
    feed_frame(1'b0, DEPTH, 0);
    check("f1_state", 32'(sif.state), 0);
    check("f1_rd_bank", 32'(sif.rd_bank), 0);
    check("f1_buf_bank", 32'(sif.buf_bank), 1);
    check("f1_frame_ready", 32'(sif.frame_ready), 1);
    check("f1_frame_cnt", 32'(sif.frame_cnt), 1);
    check("f1_writes_done", 32'(exp_q.size()), 0);

    // Host holds the read bank across the end of a continuous frame.
    sif.host_lock = 1'b1;
    tick(2);
    check("lock_clears_ready", 32'(sif.frame_ready), 0);
    sif.continuous = 1'b1;
    tick(1);
    check("cont_to_wait", 32'(sif.state), 1);
    trigger();
    feed_frame(1'b1, DEPTH, 1);
    check("hold_state", 32'(sif.state), 3);
    check("hold_frame_cnt", 32'(sif.frame_cnt), 1);
    check("hold_buf_bank", 32'(sif.buf_bank), 1);
    for (int i = 0; i < 5; i++) sample(DW'(12'hABC + i), 1'b0, 1'b0, '0);
    check("overrun_5", 32'(sif.overrun_cnt), 5);
    check("still_holding", 32'(sif.state), 3);
    check("hold_ready_low", 32'(sif.frame_ready), 0);
    sif.host_lock = 1'b0;
    tick(1);
    check("swap_state", 32'(sif.state), 1);
    check("swap_buf_bank", 32'(sif.buf_bank), 0);
    check("swap_rd_bank", 32'(sif.rd_bank), 1);
    check("swap_ready", 32'(sif.frame_ready), 1);
    check("swap_frame_cnt", 32'(sif.frame_cnt), 2);

    // Front end loses lock mid-frame: partial frame dropped, same bank.
    trigger();
    feed_frame(1'b0, 300, 2);
    sif.stable = 1'b0;
    tick(1);
    check("unstable_state", 32'(sif.state), 1);
    check("unstable_frame_cnt", 32'(sif.frame_cnt), 2);
    check("unstable_bank", 32'(sif.buf_bank), 0);
    tick(1);
    sif.stable = 1'b1;
    trigger();
    check("retrig_capture", 32'(sif.state), 2);
    feed_frame(1'b0, 500, 3);

    // Abort with arm and a sample strobe in the same clock at addr 500.
    sif.continuous    = 1'b0;
    sif.abort         = 1'b1;
    sif.arm           = 1'b1;
    sif.sample_valid  = 1'b1;
    sif.sync_adc_data = 12'h5A5;
    tick(1);
    sif.abort        = 1'b0;
    sif.arm          = 1'b0;
    sif.sample_valid = 1'b0;
    check("abort_state", 32'(sif.state), 0);
    tick(3);
    check("abort_stays_idle", 32'(sif.state), 0);
    check("abort_buf_bank", 32'(sif.buf_bank), 0);
    check("abort_rd_bank", 32'(sif.rd_bank), 1);
    check("abort_ready", 32'(sif.frame_ready), 1);
    check("abort_frame_cnt", 32'(sif.frame_cnt), 2);
    check("abort_overrun", 32'(sif.overrun_cnt), 5);
    sample(12'h111, 1'b0, 1'b0, '0);
    sif.arm = 1'b1;
    tick(1);
    sif.arm = 1'b0;
    check("rearm_wait", 32'(sif.state), 1);
    trigger();
    feed_frame(1'b0, 3, 4);

    // arm in CAPTURE is ignored; then asynchronous reset mid-frame.
    sif.arm = 1'b1;
    tick(1);
    sif.arm = 1'b0;
    check("arm_ignored", 32'(sif.state), 2);
    sif.sample_valid  = 1'b1;
    sif.sync_adc_data = 12'hFED;
    tick(1);
    sif.sample_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // No comparator edge: only the auto-trigger build may leave WAIT_TRIG.
    sif.arm = 1'b1;
    tick(1);
    sif.arm = 1'b0;
    check("auto_wait", 32'(sif.state), 1);
    for (int i = 0; i < 15; i++) sample(DW'(i), 1'b0, 1'b0, '0);
    check("auto_15", 32'(sif.state), 1);
    sample(12'h0FF, 1'b0, 1'b0, '0);
`ifdef CAPTURE_SEQUENCER_AUTO_TRIG_EN
    check("auto_16_capture", 32'(sif.state), 2);
    feed_frame(1'b0, 2, 5);
`else
    check("auto_16_wait", 32'(sif.state), 1);
    for (int i = 0; i < 20; i++) sample(DW'(i), 1'b0, 1'b0, '0);
    check("no_auto_trigger", 32'(sif.state), 1);
`endif
    tick(2);
    check("writes_drained", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
